// File: rtl/recv_m2.sv
// Manchester-II frame receiver: synchronizes the bzi/boi pair, hunts for the
// 000111 sync head, decodes 16 data bits plus odd parity and posts status flags.
module recv_m2 #(
  parameter int unsigned HB_CLKS = 8
) (
  input  logic        clock_system,
  input  logic        reset_low,
  input  logic        m2_bzi,
  input  logic        m2_boi,
  input  logic        rd_low,
  input  logic        ma_en,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        rx_ready,
  output logic        rx_err,
  output logic [3:0]  err_flags,
  output logic        rx_overrun
);

  localparam int unsigned CNT_W = $clog2(HB_CLKS);
  localparam int unsigned K_W   = 6;
  localparam int unsigned N_HB  = 40;

  typedef enum logic [1:0] {S_IDLE_WAIT, S_ARM, S_SAMPLE, S_EVAL} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_bz_s1, r_bz, r_bo_s1, r_bo;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [K_W-1:0]     r_k, w_k_nxt;
  logic [N_HB-1:0]    r_samp;
  logic               r_diff;
  logic               w_take, w_eval, w_start;
  logic [15:0]        w_data;
  logic               w_manch, w_sync, w_par, w_good, w_rd;

  // Two-flop synchronizers; reset low so idle must be genuinely observed
  always_ff @(posedge clock_system or negedge reset_low) begin
    if (!reset_low) begin
      r_bz_s1 <= 1'b0;
      r_bz    <= 1'b0;
      r_bo_s1 <= 1'b0;
      r_bo    <= 1'b0;
    end else begin
      r_bz_s1 <= m2_bzi;
      r_bz    <= r_bz_s1;
      r_bo_s1 <= m2_boi;
      r_bo    <= r_bo_s1;
    end
  end

  always_ff @(posedge clock_system or negedge reset_low) begin
    if (!reset_low) r_state <= S_IDLE_WAIT;
    else            r_state <= w_next;
  end

  // Next state; r_cnt counts idle clocks in IDLE_WAIT and the phase in SAMPLE
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_k_nxt   = r_k;
    w_take    = 1'b0;
    w_eval    = 1'b0;
    w_start   = 1'b0;
    case (r_state)
      S_IDLE_WAIT: begin
        if (r_bz && r_bo) begin
          if (r_cnt == CNT_W'(HB_CLKS - 1)) begin
            w_next    = S_ARM;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      S_ARM: begin
        if (!r_bz && r_bo) begin
          w_next    = S_SAMPLE;
          w_start   = 1'b1;
          w_cnt_nxt = CNT_W'(HB_CLKS / 2 - 1);
          w_k_nxt   = '0;
        end
      end
      S_SAMPLE: begin
        if (r_cnt == '0) begin
          w_cnt_nxt = CNT_W'(HB_CLKS - 1);
          w_k_nxt   = r_k + K_W'(1);
          if ((r_k == '0) && r_bz) begin
            w_next    = S_IDLE_WAIT;
            w_cnt_nxt = '0;
          end else begin
            w_take = 1'b1;
            if (r_k == K_W'(N_HB - 1)) w_next = S_EVAL;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_EVAL: begin
        w_eval    = 1'b1;
        w_next    = S_IDLE_WAIT;
        w_cnt_nxt = '0;
      end
      default: w_next = S_IDLE_WAIT;
    endcase
  end

  // Frame evaluation: sample 0 sits at bit 39, the first half of each pair carries the bit
  always_comb begin
    w_data  = '0;
    w_manch = (r_samp[1] == r_samp[0]);
    for (int p = 0; p < 16; p++) begin
      w_data[15-p] = r_samp[33-2*p];
      w_manch      = w_manch | (r_samp[33-2*p] == r_samp[32-2*p]);
    end
    w_sync = (r_samp[39:34] != 6'b000111);
    w_par  = ~(^{w_data, r_samp[1]});
    w_good = !(r_diff || w_sync || w_manch || w_par);
    w_rd   = !rd_low && ma_en;
  end

  always_ff @(posedge clock_system or negedge reset_low) begin
    if (!reset_low) begin
      r_cnt      <= '0;
      r_k        <= '0;
      r_samp     <= '0;
      r_diff     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_ready   <= 1'b0;
      rx_err     <= 1'b0;
      err_flags  <= '0;
      rx_overrun <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_k      <= w_k_nxt;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (w_start)                    r_diff <= 1'b0;
      else if (w_take && (r_bz == r_bo)) r_diff <= 1'b1;
      if (w_take) r_samp <= {r_samp[N_HB-2:0], r_bz};
      if (w_eval && w_good) begin
        rx_data   <= w_data;
        rx_valid  <= 1'b1;
        err_flags <= '0;
      end else if (w_eval) begin
        rx_err    <= 1'b1;
        err_flags <= {r_diff, w_sync, w_manch, w_par};
      end
      // A good-frame set wins over a coincident read
      if (w_eval && w_good) rx_ready <= 1'b1;
      else if (w_rd)        rx_ready <= 1'b0;
      if (w_eval && w_good && rx_ready) rx_overrun <= 1'b1;
      else if (w_rd)                    rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_recv_m2.sv
// Directed bench for recv_m2: builds Manchester frames, queues expected
// results and checks them when the receiver reports a frame.
module tb_recv_m2;

  localparam int unsigned HB = 8;
  // 2 sync clocks + start-to-EVAL + the edge ending EVAL, from the first driven half-bit
  localparam int LAT = 2 + HB/2 + 39*HB + 1 + 1;

  typedef struct {
    bit          good;
    logic [15:0] data;
    logic [3:0]  flags;
  } exp_t;

  logic        clock_system = 1'b0;
  logic        reset_low;
  logic        m2_bzi, m2_boi, rd_low, ma_en;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready, rx_err, rx_overrun;
  logic [3:0]  err_flags;

  exp_t        sb[$];
  logic [15:0] exp_data;
  int          n_checks, n_fail, cyc, t_start, lat;
  logic [39:0] nomask;

  recv_m2 #(.HB_CLKS(HB)) dut (
    .clock_system(clock_system), .reset_low(reset_low),
    .m2_bzi(m2_bzi), .m2_boi(m2_boi), .rd_low(rd_low), .ma_en(ma_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_err(rx_err), .err_flags(err_flags), .rx_overrun(rx_overrun)
  );

  always #5 clock_system = ~clock_system;

  task automatic tick();
    @(posedge clock_system);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [39:0] mk_frame(input logic [15:0] d, input logic c);
    logic [39:0] f;
    f[39:34] = 6'b000111;
    for (int p = 0; p < 16; p++) f[33-2*p -: 2] = d[15-p] ? 2'b10 : 2'b01;
    f[1:0] = c ? 2'b10 : 2'b01;
    return f;
  endfunction

  task automatic push_exp(input bit good, input logic [15:0] d, input logic [3:0] fl);
    exp_t e;
    if (good) exp_data = d;
    e.good  = good;
    e.data  = exp_data;
    e.flags = fl;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    m2_bzi = 1'b1;
    m2_boi = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [39:0] f, input logic [39:0] dmask,
                            input int n_hb, input int rd_at);
    t_start = cyc;
    for (int i = 0; i < n_hb * int'(HB); i++) begin
      int h;
      h      = 39 - i / int'(HB);
      m2_bzi = f[h];
      m2_boi = ~f[h] ^ dmask[h];
      rd_low = (i == rd_at) ? 1'b0 : 1'b1;
      tick();
    end
    rd_low = 1'b1;
  endtask

  task automatic wait_result(output int l);
    exp_t e;
    int   t;
    t = 0;
    while (!(rx_valid || rx_err) && t < 40) begin
      tick();
      t++;
    end
    l = cyc - t_start;
    chk("result_seen", 32'(rx_valid | rx_err), 32'd1);
    chk("sb_pending", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rx_valid", 32'(rx_valid), 32'(e.good));
      chk("rx_err", 32'(rx_err), 32'(!e.good));
      chk("rx_data", 32'(rx_data), 32'(e.data));
      chk("err_flags", 32'(err_flags), 32'(e.flags));
    end
    tick();
    chk("pulse_width", 32'({rx_valid, rx_err}), 32'd0);
  endtask

  task automatic hold_quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    repeat (n) begin
      tick();
      if (rx_valid || rx_err) pulses++;
    end
    chk(tag, 32'(pulses), 32'd0);
  endtask

  task automatic do_read(input logic en);
    rd_low = 1'b0;
    ma_en  = en;
    tick();
    rd_low = 1'b1;
    ma_en  = 1'b1;
  endtask

  initial begin
    logic [39:0] f;
    logic [39:0] dm;
    n_checks = 0; n_fail = 0; cyc = 0; t_start = 0; exp_data = '0;
    nomask = '0;
    reset_low = 1'b0; m2_bzi = 1'b1; m2_boi = 1'b1; rd_low = 1'b1; ma_en = 1'b1;
    repeat (3) tick();
    chk("rst_data", 32'(rx_data), 32'h0);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_ready", 32'(rx_ready), 32'h0);
    chk("rst_err", 32'(rx_err), 32'h0);
    chk("rst_flags", 32'(err_flags), 32'h0);
    chk("rst_ovr", 32'(rx_overrun), 32'h0);
    reset_low = 1'b1;
    idle(16);

    // Good frame, latency, then line parked at the start level must not re-arm
    push_exp(1'b1, 16'hA5C3, 4'h0);
    send_frame(mk_frame(16'hA5C3, ~^16'hA5C3), nomask, 40, -1);
    wait_result(lat);
    chk("latency", 32'(lat), 32'(LAT));
    chk("ready_after_good", 32'(rx_ready), 32'd1);
    chk("ovr_after_good", 32'(rx_overrun), 32'd0);
    hold_quiet("no_rearm_low_hold", 340);
    idle(16);

    // Parity error on a different word: data keeps the last good value
    push_exp(1'b0, 16'h0, 4'b0001);
    send_frame(mk_frame(16'h5A3C, ^16'h5A3C), nomask, 40, -1);
    wait_result(lat);
    idle(16);

    // Manchester error: bit 7 (a 1) sent as 11, parity still consistent
    f = mk_frame(16'hA5C3, ~^16'hA5C3);
    f[17:16] = 2'b11;
    push_exp(1'b0, 16'h0, 4'b0010);
    send_frame(f, nomask, 40, -1);
    wait_result(lat);
    idle(16);

    // Sync error: head 001111
    f = mk_frame(16'hA5C3, ~^16'hA5C3);
    f[39:34] = 6'b001111;
    push_exp(1'b0, 16'h0, 4'b0100);
    send_frame(f, nomask, 40, -1);
    wait_result(lat);
    idle(16);

    // Differential error on half-bit 20
    dm = '0;
    dm[39-20] = 1'b1;
    push_exp(1'b0, 16'h0, 4'b1000);
    send_frame(mk_frame(16'h0F0F, ~^16'h0F0F), dm, 40, -1);
    wait_result(lat);
    chk("ready_kept_bad", 32'(rx_ready), 32'd1);
    idle(16);

    // Read without decode enable does nothing; a real read clears
    do_read(1'b0);
    chk("read_no_en", 32'(rx_ready), 32'd1);
    do_read(1'b1);
    chk("read_clr_ready", 32'(rx_ready), 32'd0);

    // Two good frames without a read: overrun
    push_exp(1'b1, 16'h1234, 4'h0);
    send_frame(mk_frame(16'h1234, ~^16'h1234), nomask, 40, -1);
    wait_result(lat);
    chk("ovr_first", 32'(rx_overrun), 32'd0);
    idle(16);
    push_exp(1'b1, 16'h8001, 4'h0);
    send_frame(mk_frame(16'h8001, ~^16'h8001), nomask, 40, -1);
    wait_result(lat);
    chk("ovr_second", 32'(rx_overrun), 32'd1);
    chk("data_second", 32'(rx_data), 32'h8001);
    do_read(1'b1);
    chk("read_clr_ready2", 32'(rx_ready), 32'd0);
    chk("read_clr_ovr", 32'(rx_overrun), 32'd0);
    idle(16);

    // Read on the update clock with ready low: set wins, no overrun
    push_exp(1'b1, 16'hBEEF, 4'h0);
    send_frame(mk_frame(16'hBEEF, ~^16'hBEEF), nomask, 40, LAT - 1);
    chk("coinc_ready", 32'(rx_ready), 32'd1);
    chk("coinc_ovr", 32'(rx_overrun), 32'd0);
    wait_result(lat);
    idle(16);

    // Read on the update clock with ready already high: overrun set
    push_exp(1'b1, 16'h0001, 4'h0);
    send_frame(mk_frame(16'h0001, ~^16'h0001), nomask, 40, LAT - 1);
    chk("coinc2_ready", 32'(rx_ready), 32'd1);
    chk("coinc2_ovr", 32'(rx_overrun), 32'd1);
    wait_result(lat);
    idle(16);

    // Two-clock glitch: no activity, state untouched
    m2_bzi = 1'b0;
    repeat (2) tick();
    m2_bzi = 1'b1;
    hold_quiet("glitch_quiet", 400);
    chk("glitch_data", 32'(rx_data), 32'h0001);
    chk("glitch_ready", 32'(rx_ready), 32'd1);

    // Reset at half-bit 15, then a clean frame
    send_frame(mk_frame(16'h7777, ~^16'h7777), nomask, 15, -1);
    reset_low = 1'b0;
    #1;
    chk("mid_rst_data", 32'(rx_data), 32'h0);
    chk("mid_rst_ready", 32'(rx_ready), 32'h0);
    chk("mid_rst_ovr", 32'(rx_overrun), 32'h0);
    chk("mid_rst_pulses", 32'({rx_valid, rx_err, err_flags}), 32'h0);
    exp_data = '0;
    idle(3);
    reset_low = 1'b1;
    idle(16);
    push_exp(1'b1, 16'hC0DE, 4'h0);
    send_frame(mk_frame(16'hC0DE, ~^16'hC0DE), nomask, 40, -1);
    wait_result(lat);
    chk("post_rst_latency", 32'(lat), 32'(LAT));
    chk("post_rst_ready", 32'(rx_ready), 32'd1);
    chk("post_rst_ovr", 32'(rx_overrun), 32'd0);
    idle(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
